// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the five-stage MIPS core.
//   - primary opcode constants
//   - ALU-op class constants carried from the decoder to EX
//   - packed control bundle latched by the ID/EX register
//   - RUN/HOLD state encoding for the ID/EX hazard FSM
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU-op classes
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    // Control bits that travel from ID into EX (id_jump stays in ID)
    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       beq;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Hazard FSM states
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/id_ex_hazard.sv
// id_ex_hazard: hazard detection and bubble-insertion FSM for the ID/EX register.
//   Detects load-use hazards and, when ID_EX_BRANCH_HAZARD_EN is defined,
//   branch-in-ID operand hazards. A RUN/HOLD state machine stretches a
//   branch-after-load hazard to two bubbles.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_mem_read, ex_reg_write  registered controls of the instruction in EX
//   ex_wreg                    destination register of the instruction in EX
//   id_rs, id_rt               source indices of the instruction in ID
//   id_alu_src, id_mem_write,
//   id_branch                  ID controls that decide whether rt is read
//   id_flush                   squash the ID instruction
//   stall                      hold PC and IF/ID (combinational)
//   bubble                     load a bubble into ID/EX this cycle
// Configuration macro: ID_EX_BRANCH_HAZARD_EN
module id_ex_hazard
    import mips_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_mem_read,
    input  logic          ex_reg_write,
    input  logic [RW-1:0] ex_wreg,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_alu_src,
    input  logic          id_mem_write,
    input  logic          id_branch,
    input  logic          id_flush,
    output logic          stall,
    output logic          bubble
);

    state_e state_q;
    state_e state_d;
    logic   uses_rt_s;
    logic   wreg_nz_s;
    logic   load_use_s;
    logic   br_haz_s;
    logic   need_two_s;
    logic   hazard_s;
    logic   stall_s;
    logic   bubble_s;

    // rt is a real source for R-type ALU ops, store data and branch compares
    assign uses_rt_s  = ~id_alu_src | id_mem_write | id_branch;
    assign wreg_nz_s  = (ex_wreg != {RW{1'b0}});
    assign load_use_s = ex_mem_read & wreg_nz_s &
                        ((ex_wreg == id_rs) | (uses_rt_s & (ex_wreg == id_rt)));

`ifdef ID_EX_BRANCH_HAZARD_EN
    // Branch compares in ID, so any in-flight writer of its operands must
    // drain first; a load needs one extra cycle to reach the forwarding point.
    assign br_haz_s   = id_branch & ex_reg_write & wreg_nz_s &
                        ((ex_wreg == id_rs) | (ex_wreg == id_rt));
    assign need_two_s = br_haz_s & ex_mem_read;
`else
    logic unused_reg_write_s;
    assign unused_reg_write_s = ex_reg_write;
    assign br_haz_s   = 1'b0;
    assign need_two_s = 1'b0;
`endif

    assign hazard_s = load_use_s | br_haz_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and stall/bubble decode
    always_comb begin
        state_d  = state_q;
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        case (state_q)
            RUN: begin
                if (hazard_s) begin
                    // A coinciding flush is absorbed by the bubble; stall still wins
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    if (need_two_s) begin
                        state_d = HOLD;
                    end else begin
                        state_d = RUN;
                    end
                end else if (id_flush) begin
                    bubble_s = 1'b1;
                end else begin
                    bubble_s = 1'b0;
                end
            end
            HOLD: begin
                // Second bubble; detection is off because EX already holds a bubble
                stall_s  = 1'b1;
                bubble_s = 1'b1;
                state_d  = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign stall  = stall_s;
    assign bubble = bubble_s;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the five-stage MIPS core.
//   Latches decoder controls and operand data into EX every cycle, replacing
//   the controls (and ex_wreg) with zero when id_ex_hazard requests a bubble.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   id_*              decoder controls, operands and register indices from ID
//   id_flush          squash the ID instruction
//   stall             hold PC and IF/ID (combinational)
//   ex_*              registered controls/data for EX; ex_wreg is the
//                     resolved destination (id_reg_dst ? id_rd : id_rt)
// Configuration macro: ID_EX_BRANCH_HAZARD_EN (enables branch-in-ID hazards)
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_reg_dst,
    input  logic          id_jump,
    input  logic          id_branch,
    input  logic          id_mem_read,
    input  logic          id_mem_to_reg,
    input  logic          id_mem_write,
    input  logic          id_alu_src,
    input  logic          id_reg_write,
    input  logic          id_beq,
    input  logic [1:0]    id_alu_op,
    input  logic [DW-1:0] id_pc4,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          id_flush,
    output logic          stall,
    output logic          ex_reg_dst,
    output logic          ex_branch,
    output logic          ex_mem_read,
    output logic          ex_mem_to_reg,
    output logic          ex_mem_write,
    output logic          ex_alu_src,
    output logic          ex_reg_write,
    output logic          ex_beq,
    output logic [1:0]    ex_alu_op,
    output logic [DW-1:0] ex_pc4,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_wreg
);

    ctrl_t         ctrl_q,    ctrl_d;
    logic [RW-1:0] wreg_q,    wreg_d;
    logic [DW-1:0] pc4_q,     pc4_d;
    logic [DW-1:0] rs_data_q, rs_data_d;
    logic [DW-1:0] rt_data_q, rt_data_d;
    logic [DW-1:0] imm_q,     imm_d;
    logic [RW-1:0] rs_q,      rs_d;
    logic [RW-1:0] rt_q,      rt_d;
    logic          bubble_s;

    // Jumps resolve in ID and never reach EX
    logic unused_jump_s;
    assign unused_jump_s = id_jump;

    id_ex_hazard #(.RW(RW)) u_hazard (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_mem_read  (ctrl_q.mem_read),
        .ex_reg_write (ctrl_q.reg_write),
        .ex_wreg      (wreg_q),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_alu_src   (id_alu_src),
        .id_mem_write (id_mem_write),
        .id_branch    (id_branch),
        .id_flush     (id_flush),
        .stall        (stall),
        .bubble       (bubble_s)
    );

    // Next contents of the register bank: data always flows, controls are
    // zeroed on a bubble so EX sees a harmless nop
    always_comb begin
        ctrl_d    = ctrl_t'({CTRL_W{1'b0}});
        wreg_d    = {RW{1'b0}};
        pc4_d     = id_pc4;
        rs_data_d = id_rs_data;
        rt_data_d = id_rt_data;
        imm_d     = id_imm;
        rs_d      = id_rs;
        rt_d      = id_rt;
        if (!bubble_s) begin
            ctrl_d.reg_dst    = id_reg_dst;
            ctrl_d.branch     = id_branch;
            ctrl_d.mem_read   = id_mem_read;
            ctrl_d.mem_to_reg = id_mem_to_reg;
            ctrl_d.mem_write  = id_mem_write;
            ctrl_d.alu_src    = id_alu_src;
            ctrl_d.reg_write  = id_reg_write;
            ctrl_d.beq        = id_beq;
            ctrl_d.alu_op     = id_alu_op;
            wreg_d            = id_reg_dst ? id_rd : id_rt;
        end else begin
            ctrl_d = ctrl_t'({CTRL_W{1'b0}});
            wreg_d = {RW{1'b0}};
        end
    end

    // ID/EX register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= ctrl_t'({CTRL_W{1'b0}});
            wreg_q    <= {RW{1'b0}};
            pc4_q     <= {DW{1'b0}};
            rs_data_q <= {DW{1'b0}};
            rt_data_q <= {DW{1'b0}};
            imm_q     <= {DW{1'b0}};
            rs_q      <= {RW{1'b0}};
            rt_q      <= {RW{1'b0}};
        end else begin
            ctrl_q    <= ctrl_d;
            wreg_q    <= wreg_d;
            pc4_q     <= pc4_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
        end
    end

    assign ex_reg_dst    = ctrl_q.reg_dst;
    assign ex_branch     = ctrl_q.branch;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_beq        = ctrl_q.beq;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_pc4        = pc4_q;
    assign ex_rs_data    = rs_data_q;
    assign ex_rt_data    = rt_data_q;
    assign ex_imm        = imm_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_wreg       = wreg_q;

endmodule
